// File: rtl/ps2_scan_controller_if.sv
// rtl/ps2_scan_controller_if.sv - byte-in / key-event-out bundle of the PS2 scan controller
interface ps2_scan_controller_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       RX_data;
  logic             RX_valid;
  logic [7:0]       EV_code;
  logic             EV_ext;
  logic             EV_break;
  logic             EV_valid;
  logic             EV_ready;
  logic [7:0]       DISP_code;
  logic [CNT_W-1:0] FIFO_count;
  logic             OVERFLOW;
  logic             CLR_OVF;

  modport master (
    output RX_data, RX_valid, EV_ready, CLR_OVF,
    input  EV_code, EV_ext, EV_break, EV_valid, DISP_code, FIFO_count, OVERFLOW
  );

  modport slave (
    input  RX_data, RX_valid, EV_ready, CLR_OVF,
    output EV_code, EV_ext, EV_break, EV_valid, DISP_code, FIFO_count, OVERFLOW
  );
endinterface

// File: rtl/ps2_scan_controller.sv
// rtl/ps2_scan_controller.sv - PS2 scan byte sequencer with key-event FIFO and held-key display code
module ps2_scan_controller #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 50000
) (
  input logic CLOCK,
  input logic RESET,
  ps2_scan_controller_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // bit0 = E0 seen, bit1 = F0 seen, so a completing byte reads ext/break straight off the state
  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_GOT_E0   = 2'b01;
  localparam logic [1:0] S_GOT_F0   = 2'b10;
  localparam logic [1:0] S_GOT_E0F0 = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       disp_q, disp_d;
  logic             ovf_q, ovf_d;

  logic       emit, emit_ext, emit_brk;
  logic       empty, full, pop, push, drop;
  logic [9:0] head;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (bus.RX_valid) begin
      tmo_d = '0;
      if (bus.RX_data == 8'h00 || bus.RX_data == 8'hFF) begin
        state_d = S_IDLE;
      end else if (bus.RX_data == 8'hE0) begin
        state_d = state_q | S_GOT_E0;
      end else if (bus.RX_data == 8'hF0) begin
        state_d = state_q | S_GOT_F0;
      end else begin
        emit     = 1'b1;
        emit_ext = state_q[0];
        emit_brk = state_q[1];
        state_d  = S_IDLE;
      end
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign pop   = !empty && bus.EV_ready;
  assign push  = emit && (!full || pop);
  assign drop  = emit && full && !pop;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d   = ovf_q;
    if (drop)             ovf_d = 1'b1;
    else if (bus.CLR_OVF) ovf_d = 1'b0;
    disp_d = disp_q;
    if (emit && !emit_brk)                           disp_d = bus.RX_data;
    else if (emit && emit_brk && bus.RX_data == disp_q) disp_d = 8'h00;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      disp_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      count_q  <= count_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the count alone decides what is visible
  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wr_ptr_q] <= {emit_ext, emit_brk, bus.RX_data};
  end

  assign bus.EV_valid   = !empty;
  assign bus.EV_code    = empty ? 8'h00 : head[7:0];
  assign bus.EV_ext     = !empty && head[9];
  assign bus.EV_break   = !empty && head[8];
  assign bus.DISP_code  = disp_q;
  assign bus.FIFO_count = count_q;
  assign bus.OVERFLOW   = ovf_q;
endmodule

// File: tb/tb_ps2_scan_controller.sv
// tb/tb_ps2_scan_controller.sv - directed and random stimulus against a key-event reference model
module tb_ps2_scan_controller;
  localparam int FD = 4;
  localparam int TO = 16;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  ps2_scan_controller_if #(.FIFO_DEPTH(FD)) bus ();
  ps2_scan_controller #(.FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending prefix flags, idle gap, event queue, held key, sticky overflow
  logic [9:0] m_q[$];
  logic       m_ext, m_brk, m_ovf;
  int         m_gap;
  logic [7:0] m_disp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_q.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_ovf  = 1'b0;
    m_gap  = 0;
    m_disp = 8'h00;
  endtask

  task automatic compare_all;
    logic [9:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 10'h000;
    check("EV_valid",   32'(bus.EV_valid),   32'(m_q.size() != 0));
    check("EV_code",    32'(bus.EV_code),    32'(h[7:0]));
    check("EV_ext",     32'(bus.EV_ext),     32'(h[9]));
    check("EV_break",   32'(bus.EV_break),   32'(h[8]));
    check("FIFO_count", 32'(bus.FIFO_count), 32'(m_q.size()));
    check("DISP_code",  32'(bus.DISP_code),  32'(m_disp));
    check("OVERFLOW",   32'(bus.OVERFLOW),   32'(m_ovf));
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic pop, emit, e_ext, e_brk, dropped;
    pop   = r && (m_q.size() != 0);
    emit  = 1'b0;
    e_ext = 1'b0;
    e_brk = 1'b0;
    if (v) begin
      m_gap = 0;
      if (d == 8'h00 || d == 8'hFF) begin
        m_ext = 1'b0; m_brk = 1'b0;
      end else if (d == 8'hE0) begin
        m_ext = 1'b1;
      end else if (d == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        emit = 1'b1; e_ext = m_ext; e_brk = m_brk;
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end else if (m_ext || m_brk) begin
      m_gap++;
      if (m_gap >= TO) begin
        m_ext = 1'b0; m_brk = 1'b0; m_gap = 0;
      end
    end
    dropped = emit && (m_q.size() == FD) && !pop;
    if (pop) void'(m_q.pop_front());
    if (emit && !dropped) m_q.push_back({e_ext, e_brk, d});
    if (dropped) m_ovf = 1'b1;
    else if (c)  m_ovf = 1'b0;
    if (emit && !e_brk)                 m_disp = d;
    else if (emit && e_brk && d == m_disp) m_disp = 8'h00;
  endtask

  // Called just after a falling edge; returns just after the next one with outputs checked
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
    bus.RX_valid = v;
    bus.RX_data  = d;
    bus.EV_ready = r;
    bus.CLR_OVF  = c;
    model_step(v, d, r, c);
    @(negedge CLOCK);
    compare_all();
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain;
    for (int i = 0; i < FD + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    bus.RX_valid = 1'b0;
    bus.EV_ready = 1'b0;
    bus.CLR_OVF  = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  logic [7:0] pick_tbl [12];

  initial begin
    pick_tbl = '{8'h01, 8'h02, 8'h03, 8'h1C, 8'h2A, 8'h75, 8'hE0, 8'hF0,
                 8'hE0, 8'hF0, 8'h00, 8'hFF};
    bus.RX_valid = 1'b0;
    bus.RX_data  = 8'h00;
    bus.EV_ready = 1'b0;
    bus.CLR_OVF  = 1'b0;
    model_reset();
    @(negedge CLOCK);
    do_reset();

    send(8'h1C);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    send(8'h1C); send(8'hF0); send(8'h2A);
    drain();

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'hE0); send(8'h75);
    drain();

    send(8'hE0); idle(TO); send(8'h1C);
    send(8'hE0); idle(TO - 1); send(8'h1C);
    send(8'hE0); send(8'hFF); send(8'h1C);
    drain();

    for (int i = 1; i <= 5; i++) send(8'(i));
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h06, 1'b1, 1'b0);
    cycle(1'b1, 8'h07, 1'b0, 1'b1);
    drain();

    send(8'hE0);
    do_reset();
    send(8'h75);
    drain();

    for (int i = 0; i < 3000; i++) begin
      logic v, r, c;
      logic [7:0] d;
      if ((i % 400) == 200) begin
        do_reset();
      end else if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < int'($urandom_range(TO - 2, TO + 1)); k++)
          cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        v = ($urandom_range(0, 2) != 0);
        d = pick_tbl[$urandom_range(0, 11)];
        r = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        c = ($urandom_range(0, 15) == 0);
        cycle(v, d, r, c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
